mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
MEM/WB pipeline register and write-back stage. It sits directly downstream of the memory unit and consumes its 20-bit result bundle, its stall, and its stack-pop side outputs (accumulated PC, popped flags). It owns the 8x16 register file with two bypassed read ports for decode. It also drives the PC-reload and flag-restore requests back to fetch and the flag register, plus a retired-writeback counter.

Parameters:
DATA_W, 16, register/data width
REG_N, 8, number of architectural registers
ADDR_W, 3, register index width (log2 REG_N)
CNT_W, 16, retired-writeback counter width

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous reset, active-high
mem_out  in  20  memory-unit bundle: [19]=wb, [18:16]=dst, [15:0]=data
mem_stall  in  1  memory unit mid multi-cycle stack sequence; bundle not final
flush  in  1  kill the instruction currently entering this stage
acc_pc  in  32  PC reassembled from stack pops
mem_wsp  in  1  acc_pc complete, request PC reload
flag_sel  in  1  popped flags valid on flags_in
flags_in  in  3  popped flags
rd_addr_a  in  ADDR_W  read port A index
rd_addr_b  in  ADDR_W  read port B index
rd_data_a  out  DATA_W  read port A data (bypassed)
rd_data_b  out  DATA_W  read port B data (bypassed)
wb_valid  out  1  latched stage holds a committing write
wb_dst  out  ADDR_W  latched destination (forwarding tag)
wb_data  out  DATA_W  latched result (forwarding data)
pc_load  out  1  one-cycle PC reload request
pc_target  out  32  reload target, held until next reload
flags_load  out  1  one-cycle flag restore request
flags_out  out  3  restored flags, held until next restore
retired  out  CNT_W  count of committed register writes

Behaviour:
- Reset (rst=1 at edge): wb_valid=0, wb_dst=0, wb_data=0, all registers=0, pc_load=0, pc_target=0, flags_load=0, flags_out=0, retired=0. Reset overrides every other input in the same cycle.
- Stage latch, each edge:
  - flush=1 or mem_stall=1: wb_valid<=0 (bubble). dst and data take mem_out values but are don't-care.
  - Otherwise: wb_valid<=mem_out[19], wb_dst<=mem_out[18:16], wb_data<=mem_out[15:0].
  - flush and mem_stall together: bubble.
- Register write: at each edge, if wb_valid=1 then reg[wb_dst]<=wb_data. The write occurs one cycle after latching, so total latency from mem_out to register = 2 edges.
- Read ports are combinational.
  - rd_data_x = wb_data if wb_valid and rd_addr_x==wb_dst; else reg[rd_addr_x].
  - Write-first semantics: decode sees the pending write in the same cycle it commits.
  - Both ports may hit the bypass simultaneously.
- Back-to-back writes to the same dst: the later one wins. Each commits in order, and the bypass always reflects the youngest latched value.
- PC reload: edge with mem_wsp=1 and flush=0 sets pc_load<=1 and pc_target<=acc_pc. Otherwise pc_load<=0.
  - pc_load is a single-cycle pulse even if mem_wsp stays high.
  - Rising-edge detect on mem_wsp via a 1-bit history register, cleared on reset.
  - mem_wsp is not gated by mem_stall: the memory unit asserts it on the final pop.
- Flag restore: same pulse rule on flag_sel. flags_load<=1 and flags_out<=flags_in on the rising edge of flag_sel, gated by flush=0.
- Flag restore and PC reload in the same cycle: both pulse. There is no priority between them.
- retired increments by 1 on each edge where wb_valid=1 (i.e., a register write commits). It wraps from 2^CNT_W-1 to 0 without saturation.
- Reset mid stack sequence: all state clears, any pending pulse is lost, and the edge-detect history clears. A mem_wsp still high after reset deasserts produces one pulse.

Test Plan:
- Reset, then mem_out={1,3'd5,16'hBEEF} for one cycle -> wb_valid=1,wb_dst=5 next cycle; rd_addr_a=5 returns BEEF via bypass that cycle; reg[5]=BEEF after following edge; retired=1.
- Same bundle with mem_stall=1 for 2 cycles then 0 -> wb_valid=0 during stall, single commit after; retired increments once.
- Write R2=0x0001 then R2=0x0002 back-to-back, rd_addr_a=rd_addr_b=2 -> reads 0001 then 0002 then 0002; reg[2] final 0002.
- flush=1 coincident with mem_out={1,3'd1,16'h1234} -> no write, reg[1] stays 0, retired unchanged.
- acc_pc=32'h0000_0100, mem_wsp high 3 cycles, flag_sel high 2 cycles with flags_in=3'b101 -> pc_load and flags_load each pulse exactly one cycle; pc_target=0x100 and flags_out=101 held thereafter.
- Preload retired to 0xFFFF via 65535 commits, then one more -> retired=0x0000; assert rst mid-write -> all outputs and registers 0 next cycle.

Source files
------------

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and write-back stage: latches the memory-unit bundle,
// owns the bypassed register file, and pulses PC-reload / flag-restore requests.
module mem_wb_stage #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned REG_N  = 8,
   parameter int unsigned ADDR_W = 3,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [19:0]       mem_out,
   input  logic              mem_stall,
   input  logic              flush,
   input  logic [31:0]       acc_pc,
   input  logic              mem_wsp,
   input  logic              flag_sel,
   input  logic [2:0]        flags_in,
   input  logic [ADDR_W-1:0] rd_addr_a,
   input  logic [ADDR_W-1:0] rd_addr_b,
   output logic [DATA_W-1:0] rd_data_a,
   output logic [DATA_W-1:0] rd_data_b,
   output logic              wb_valid,
   output logic [ADDR_W-1:0] wb_dst,
   output logic [DATA_W-1:0] wb_data,
   output logic              pc_load,
   output logic [31:0]       pc_target,
   output logic              flags_load,
   output logic [2:0]        flags_out,
   output logic [CNT_W-1:0]  retired
);

   logic              wb_valid_q,   wb_valid_d;
   logic [ADDR_W-1:0] wb_dst_q,     wb_dst_d;
   logic [DATA_W-1:0] wb_data_q,    wb_data_d;
   logic [DATA_W-1:0] regs_q [REG_N];
   logic [DATA_W-1:0] regs_d [REG_N];
   logic              pc_load_q,    pc_load_d;
   logic [31:0]       pc_target_q,  pc_target_d;
   logic              flags_load_q, flags_load_d;
   logic [2:0]        flags_out_q,  flags_out_d;
   logic [CNT_W-1:0]  retired_q,    retired_d;
   logic              wsp_hist_q,   wsp_hist_d;
   logic              fsel_hist_q,  fsel_hist_d;

   always_comb begin
      // A stalled bundle is not final, so it enters as a bubble just like a flush.
      wb_valid_d = mem_out[19] & ~flush & ~mem_stall;
      wb_dst_d   = mem_out[16 +: ADDR_W];
      wb_data_d  = mem_out[DATA_W-1:0];

      regs_d = regs_q;
      if (wb_valid_q) begin
         regs_d[wb_dst_q] = wb_data_q;
      end
      retired_d = retired_q + CNT_W'(wb_valid_q);

      wsp_hist_d   = mem_wsp;
      pc_load_d    = mem_wsp & ~wsp_hist_q & ~flush;
      pc_target_d  = pc_load_d ? acc_pc : pc_target_q;

      fsel_hist_d  = flag_sel;
      flags_load_d = flag_sel & ~fsel_hist_q & ~flush;
      flags_out_d  = flags_load_d ? flags_in : flags_out_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wb_valid_q   <= 1'b0;
         wb_dst_q     <= '0;
         wb_data_q    <= '0;
         for (int unsigned i = 0; i < REG_N; i++) begin
            regs_q[i] <= '0;
         end
         pc_load_q    <= 1'b0;
         pc_target_q  <= '0;
         flags_load_q <= 1'b0;
         flags_out_q  <= '0;
         retired_q    <= '0;
         wsp_hist_q   <= 1'b0;
         fsel_hist_q  <= 1'b0;
      end else begin
         wb_valid_q   <= wb_valid_d;
         wb_dst_q     <= wb_dst_d;
         wb_data_q    <= wb_data_d;
         for (int unsigned i = 0; i < REG_N; i++) begin
            regs_q[i] <= regs_d[i];
         end
         pc_load_q    <= pc_load_d;
         pc_target_q  <= pc_target_d;
         flags_load_q <= flags_load_d;
         flags_out_q  <= flags_out_d;
         retired_q    <= retired_d;
         wsp_hist_q   <= wsp_hist_d;
         fsel_hist_q  <= fsel_hist_d;
      end
   end

   // Write-first: the latched write is visible to decode in the cycle it commits.
   assign rd_data_a = (wb_valid_q && (rd_addr_a == wb_dst_q)) ? wb_data_q : regs_q[rd_addr_a];
   assign rd_data_b = (wb_valid_q && (rd_addr_b == wb_dst_q)) ? wb_data_q : regs_q[rd_addr_b];

   assign wb_valid   = wb_valid_q;
   assign wb_dst     = wb_dst_q;
   assign wb_data    = wb_data_q;
   assign pc_load    = pc_load_q;
   assign pc_target  = pc_target_q;
   assign flags_load = flags_load_q;
   assign flags_out  = flags_out_q;
   assign retired    = retired_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: write-back latency, bypass, stall/flush bubbles,
// request pulses, counter wrap and synchronous reset.
module tb_mem_wb_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic [19:0] mem_out;
   logic        mem_stall, flush;
   logic [31:0] acc_pc;
   logic        mem_wsp, flag_sel;
   logic [2:0]  flags_in;
   logic [2:0]  rd_addr_a, rd_addr_b;
   logic [15:0] rd_data_a, rd_data_b;
   logic        wb_valid;
   logic [2:0]  wb_dst;
   logic [15:0] wb_data;
   logic        pc_load;
   logic [31:0] pc_target;
   logic        flags_load;
   logic [2:0]  flags_out;
   logic [15:0] retired;

   int n_tests = 0;
   int n_fail  = 0;
   int exp_ret = 0;

   mem_wb_stage #(.DATA_W(16), .REG_N(8), .ADDR_W(3), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .mem_out(mem_out), .mem_stall(mem_stall), .flush(flush),
      .acc_pc(acc_pc), .mem_wsp(mem_wsp), .flag_sel(flag_sel), .flags_in(flags_in),
      .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_data_a(rd_data_a),
      .rd_data_b(rd_data_b), .wb_valid(wb_valid), .wb_dst(wb_dst), .wb_data(wb_data),
      .pc_load(pc_load), .pc_target(pc_target), .flags_load(flags_load),
      .flags_out(flags_out), .retired(retired)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
      n_tests++;
      if (wb_valid !== 1'b0 || wb_dst !== 3'd0 || wb_data !== 16'h0) begin
         n_fail++;
         $display("FAIL reset_stage got v=%0b d=%0h x=%0h exp 0/0/0", wb_valid, wb_dst, wb_data);
      end
      n_tests++;
      if (pc_load !== 1'b0 || pc_target !== 32'h0 || flags_load !== 1'b0 || flags_out !== 3'b0) begin
         n_fail++;
         $display("FAIL reset_req got %0b %0h %0b %0b exp 0 0 0 0", pc_load, pc_target, flags_load, flags_out);
      end
      n_tests++;
      if (retired !== 16'h0) begin
         n_fail++;
         $display("FAIL reset_retired got %0h exp 0", retired);
      end
      for (int i = 0; i < 8; i++) begin
         rd_addr_a = 3'(i);
         rd_addr_b = 3'(7 - i);
         #1;
         n_tests++;
         if (rd_data_a !== 16'h0 || rd_data_b !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_reg%0d got a=%0h b=%0h exp 0", i, rd_data_a, rd_data_b);
         end
      end
   endtask

   task automatic test_basic_write();
      mem_out = {1'b1, 3'd5, 16'hBEEF};
      rd_addr_a = 3'd5;
      rd_addr_b = 3'd4;
      step();
      mem_out = '0;
      #1;
      n_tests++;
      if (wb_valid !== 1'b1 || wb_dst !== 3'd5 || wb_data !== 16'hBEEF) begin
         n_fail++;
         $display("FAIL basic_latch got v=%0b d=%0h x=%0h exp 1/5/beef", wb_valid, wb_dst, wb_data);
      end
      n_tests++;
      if (rd_data_a !== 16'hBEEF || rd_data_b !== 16'h0) begin
         n_fail++;
         $display("FAIL basic_bypass got a=%0h b=%0h exp beef 0", rd_data_a, rd_data_b);
      end
      n_tests++;
      if (retired !== 16'(exp_ret)) begin
         n_fail++;
         $display("FAIL basic_ret_pre got %0h exp %0h", retired, exp_ret);
      end
      step();
      exp_ret++;
      n_tests++;
      if (wb_valid !== 1'b0 || rd_data_a !== 16'hBEEF || retired !== 16'(exp_ret)) begin
         n_fail++;
         $display("FAIL basic_commit got v=%0b a=%0h r=%0h exp 0 beef %0h", wb_valid, rd_data_a, retired, exp_ret);
      end
   endtask

   task automatic test_stall();
      mem_out = {1'b1, 3'd3, 16'h1111};
      mem_stall = 1'b1;
      rd_addr_a = 3'd3;
      for (int i = 0; i < 2; i++) begin
         step();
         n_tests++;
         if (wb_valid !== 1'b0 || retired !== 16'(exp_ret) || rd_data_a !== 16'h0) begin
            n_fail++;
            $display("FAIL stall_bubble%0d got v=%0b r=%0h a=%0h exp 0 %0h 0", i, wb_valid, retired, rd_data_a, exp_ret);
         end
      end
      mem_stall = 1'b0;
      step();
      mem_out = '0;
      n_tests++;
      if (wb_valid !== 1'b1 || wb_dst !== 3'd3 || rd_data_a !== 16'h1111) begin
         n_fail++;
         $display("FAIL stall_release got v=%0b d=%0h a=%0h exp 1 3 1111", wb_valid, wb_dst, rd_data_a);
      end
      step();
      exp_ret++;
      n_tests++;
      if (wb_valid !== 1'b0 || retired !== 16'(exp_ret) || rd_data_a !== 16'h1111) begin
         n_fail++;
         $display("FAIL stall_commit got v=%0b r=%0h a=%0h exp 0 %0h 1111", wb_valid, retired, rd_data_a, exp_ret);
      end
   endtask

   task automatic test_back_to_back();
      rd_addr_a = 3'd2;
      rd_addr_b = 3'd2;
      mem_out = {1'b1, 3'd2, 16'h0001};
      step();
      mem_out = {1'b1, 3'd2, 16'h0002};
      n_tests++;
      if (rd_data_a !== 16'h0001 || rd_data_b !== 16'h0001) begin
         n_fail++;
         $display("FAIL b2b_first got a=%0h b=%0h exp 0001", rd_data_a, rd_data_b);
      end
      step();
      mem_out = '0;
      exp_ret++;
      n_tests++;
      if (rd_data_a !== 16'h0002 || rd_data_b !== 16'h0002) begin
         n_fail++;
         $display("FAIL b2b_second got a=%0h b=%0h exp 0002", rd_data_a, rd_data_b);
      end
      step();
      exp_ret++;
      n_tests++;
      if (wb_valid !== 1'b0 || rd_data_a !== 16'h0002 || rd_data_b !== 16'h0002 || retired !== 16'(exp_ret)) begin
         n_fail++;
         $display("FAIL b2b_final got v=%0b a=%0h b=%0h r=%0h exp 0 0002 0002 %0h", wb_valid, rd_data_a, rd_data_b, retired, exp_ret);
      end
   endtask

   task automatic test_flush();
      rd_addr_a = 3'd1;
      flush = 1'b1;
      mem_out = {1'b1, 3'd1, 16'h1234};
      step();
      n_tests++;
      if (wb_valid !== 1'b0 || rd_data_a !== 16'h0) begin
         n_fail++;
         $display("FAIL flush_bubble got v=%0b a=%0h exp 0 0", wb_valid, rd_data_a);
      end
      mem_stall = 1'b1;
      step();
      n_tests++;
      if (wb_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_stall got v=%0b exp 0", wb_valid);
      end
      flush = 1'b0;
      mem_stall = 1'b0;
      mem_out = '0;
      step();
      n_tests++;
      if (rd_data_a !== 16'h0 || retired !== 16'(exp_ret)) begin
         n_fail++;
         $display("FAIL flush_nowrite got a=%0h r=%0h exp 0 %0h", rd_data_a, retired, exp_ret);
      end
   endtask

   task automatic test_pulses();
      acc_pc = 32'h0000_0100;
      flags_in = 3'b101;
      mem_wsp = 1'b1;
      flag_sel = 1'b1;
      step();
      n_tests++;
      if (pc_load !== 1'b1 || pc_target !== 32'h100 || flags_load !== 1'b1 || flags_out !== 3'b101) begin
         n_fail++;
         $display("FAIL pulse_first got %0b %0h %0b %0b exp 1 100 1 101", pc_load, pc_target, flags_load, flags_out);
      end
      acc_pc = 32'h0000_0200;
      flags_in = 3'b010;
      step();
      flag_sel = 1'b0;
      n_tests++;
      if (pc_load !== 1'b0 || flags_load !== 1'b0 || pc_target !== 32'h100 || flags_out !== 3'b101) begin
         n_fail++;
         $display("FAIL pulse_second got %0b %0b %0h %0b exp 0 0 100 101", pc_load, flags_load, pc_target, flags_out);
      end
      step();
      mem_wsp = 1'b0;
      n_tests++;
      if (pc_load !== 1'b0 || flags_load !== 1'b0 || pc_target !== 32'h100) begin
         n_fail++;
         $display("FAIL pulse_third got %0b %0b %0h exp 0 0 100", pc_load, flags_load, pc_target);
      end
      step();
      mem_wsp = 1'b1;
      flag_sel = 1'b1;
      flush = 1'b1;
      step();
      n_tests++;
      if (pc_load !== 1'b0 || flags_load !== 1'b0 || pc_target !== 32'h100 || flags_out !== 3'b101) begin
         n_fail++;
         $display("FAIL pulse_flushed got %0b %0b %0h %0b exp 0 0 100 101", pc_load, flags_load, pc_target, flags_out);
      end
      flush = 1'b0;
      mem_wsp = 1'b0;
      flag_sel = 1'b0;
      step();
   endtask

   task automatic test_wrap_and_reset();
      int k;
      k = 65535 - exp_ret;
      rd_addr_a = 3'd7;
      mem_out = {1'b1, 3'd7, 16'hA5A5};
      for (int i = 0; i < k; i++) begin
         step();
      end
      mem_out = '0;
      step();
      n_tests++;
      if (retired !== 16'hFFFF || wb_valid !== 1'b0 || rd_data_a !== 16'hA5A5) begin
         n_fail++;
         $display("FAIL wrap_preload got r=%0h v=%0b a=%0h exp ffff 0 a5a5", retired, wb_valid, rd_data_a);
      end
      mem_out = {1'b1, 3'd6, 16'h7777};
      step();
      mem_out = '0;
      step();
      n_tests++;
      if (retired !== 16'h0000) begin
         n_fail++;
         $display("FAIL wrap_rollover got %0h exp 0", retired);
      end
      mem_out = {1'b1, 3'd6, 16'hCAFE};
      acc_pc = 32'hDEAD_0000;
      mem_wsp = 1'b1;
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      mem_out = '0;
      n_tests++;
      if (wb_valid !== 1'b0 || wb_dst !== 3'd0 || wb_data !== 16'h0 || retired !== 16'h0 ||
          pc_load !== 1'b0 || pc_target !== 32'h0 || flags_out !== 3'b0 || flags_load !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_mid_outputs got v=%0b d=%0h x=%0h r=%0h pl=%0b pt=%0h exp all 0",
                  wb_valid, wb_dst, wb_data, retired, pc_load, pc_target);
      end
      rd_addr_a = 3'd6;
      rd_addr_b = 3'd7;
      #1;
      n_tests++;
      if (rd_data_a !== 16'h0 || rd_data_b !== 16'h0) begin
         n_fail++;
         $display("FAIL rst_mid_regs got a=%0h b=%0h exp 0 0", rd_data_a, rd_data_b);
      end
      step();
      n_tests++;
      if (pc_load !== 1'b1 || pc_target !== 32'hDEAD_0000 || retired !== 16'h0) begin
         n_fail++;
         $display("FAIL rst_wsp_pulse got %0b %0h r=%0h exp 1 dead0000 0", pc_load, pc_target, retired);
      end
      step();
      n_tests++;
      if (pc_load !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_wsp_single got %0b exp 0", pc_load);
      end
      mem_wsp = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      mem_out = '0;
      mem_stall = 1'b0;
      flush = 1'b0;
      acc_pc = '0;
      mem_wsp = 1'b0;
      flag_sel = 1'b0;
      flags_in = '0;
      rd_addr_a = '0;
      rd_addr_b = '0;
      test_reset();
      test_basic_write();
      test_stall();
      test_back_to_back();
      test_flush();
      test_pulses();
      test_wrap_and_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
